// File: rtl/axi_wr_arbiter.sv
// Two-master round-robin write arbiter: grant held from AW through B.
// Define ARB_TIMEOUT_EN to synthesize an error response on a stuck B channel.
module axi_wr_arbiter #(
  parameter int AW_W        = 12,
  parameter int DATA_W      = 8,
  parameter int RESP_W      = 5,
  parameter int TIMEOUT_CYC = 64
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [1:0]          M_AWVALID,
  input  logic [2*AW_W-1:0]   M_AWOUT,
  output logic [1:0]          M_AWREADY,
  input  logic [1:0]          M_WVALID,
  input  logic [2*DATA_W-1:0] M_WDATA,
  input  logic [1:0]          M_WLAST,
  output logic [1:0]          M_WREADY,
  input  logic [1:0]          M_BREADY,
  output logic [1:0]          M_BVALID,
  output logic [RESP_W-1:0]   M_BRESP,
  output logic                S_AWVALID,
  output logic [AW_W-1:0]     S_AWOUT,
  input  logic                S_AWREADY,
  output logic                S_WVALID,
  output logic [DATA_W-1:0]   S_WDATA,
  output logic                S_WLAST,
  input  logic                S_WREADY,
  input  logic                S_BVALID,
  input  logic [RESP_W-1:0]   S_BRESP,
  output logic                S_BREADY,
  output logic [1:0]          GNT,
  output logic                BUSY
);

  typedef enum logic [1:0] {IDLE, ADDR, DATA, RESP} state_t;

  state_t     state;
  logic       gi;
  logic       pri;
  logic [7:0] beats;
  logic       pick;
  logic       w_hs;
  logic       b_done;
  logic       tout;
  logic       stale;

  assign pick = (&M_AWVALID) ? pri : M_AWVALID[1];
  assign BUSY = (state != IDLE);
  assign w_hs = S_WVALID && S_WREADY;

`ifdef ARB_TIMEOUT_EN
  localparam logic [15:0] TO = 16'(TIMEOUT_CYC);
  logic [15:0] tcnt;

  assign tout = (state == RESP) && (tcnt == TO);

  always_ff @(posedge clk) begin
    if (!rst) begin
      tcnt  <= '0;
      stale <= 1'b0;
    end else begin
      if (state != RESP)
        tcnt <= '0;
      else if (tcnt != TO)
        tcnt <= tcnt + 16'd1;
      // the slave may still answer after we gave up; swallow it in IDLE
      if (b_done && tout)
        stale <= 1'b1;
      else if (state == IDLE && S_BVALID)
        stale <= 1'b0;
    end
  end
`else
  assign tout  = 1'b0;
  assign stale = 1'b0;
`endif

  always_comb begin
    b_done = 1'b0;
    if (state == RESP) begin
      if (tout)
        b_done = M_BREADY[gi];
      else
        b_done = S_BVALID && M_BREADY[gi];
    end
  end

  always_comb begin
    M_AWREADY = '0;
    M_WREADY  = '0;
    M_BVALID  = '0;
    M_BRESP   = '0;
    S_AWVALID = 1'b0;
    S_AWOUT   = '0;
    S_WVALID  = 1'b0;
    S_WDATA   = '0;
    S_WLAST   = 1'b0;
    S_BREADY  = 1'b0;
    unique case (state)
      IDLE: begin
        S_BREADY = stale;
      end
      ADDR: begin
        S_AWVALID     = M_AWVALID[gi];
        S_AWOUT       = gi ? M_AWOUT[2*AW_W-1:AW_W]
                           : M_AWOUT[AW_W-1:0];
        M_AWREADY[gi] = S_AWREADY;
      end
      DATA: begin
        S_WVALID     = M_WVALID[gi];
        S_WDATA      = gi ? M_WDATA[2*DATA_W-1:DATA_W]
                          : M_WDATA[DATA_W-1:0];
        S_WLAST      = M_WLAST[gi];
        M_WREADY[gi] = S_WREADY;
      end
      RESP: begin
        if (tout) begin
          M_BVALID[gi] = 1'b1;
          M_BRESP      = {RESP_W{1'b1}};
        end else begin
          S_BREADY     = M_BREADY[gi];
          M_BVALID[gi] = S_BVALID;
          M_BRESP      = S_BRESP;
        end
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state <= IDLE;
      GNT   <= '0;
      gi    <= 1'b0;
      pri   <= 1'b0;
      beats <= '0;
    end else begin
      unique case (state)
        IDLE: begin
          if (|M_AWVALID) begin
            gi    <= pick;
            GNT   <= pick ? 2'b10 : 2'b01;
            state <= ADDR;
          end
        end
        ADDR: begin
          // a withdrawn request forfeits the grant without rotating
          if (!M_AWVALID[gi]) begin
            state <= IDLE;
            GNT   <= '0;
          end else if (S_AWREADY) begin
            state <= DATA;
          end
        end
        DATA: begin
          if (w_hs) begin
            if (beats != 8'hFF)
              beats <= beats + 8'd1;
            if (M_WLAST[gi])
              state <= RESP;
          end
        end
        RESP: begin
          if (b_done) begin
            state <= IDLE;
            GNT   <= '0;
            pri   <= ~gi;
            beats <= '0;
          end
        end
      endcase
    end
  end

endmodule

// File: tb/tb_axi_wr_arbiter.sv
// Directed scoreboard bench for axi_wr_arbiter.
// Slave-side AW and W traffic is checked against queued expectations.
module tb_axi_wr_arbiter;

  localparam int AW_W   = 12;
  localparam int DATA_W = 8;
  localparam int RESP_W = 5;

  logic                clk;
  logic                rst;
  logic [1:0]          M_AWVALID;
  logic [2*AW_W-1:0]   M_AWOUT;
  logic [1:0]          M_AWREADY;
  logic [1:0]          M_WVALID;
  logic [2*DATA_W-1:0] M_WDATA;
  logic [1:0]          M_WLAST;
  logic [1:0]          M_WREADY;
  logic [1:0]          M_BREADY;
  logic [1:0]          M_BVALID;
  logic [RESP_W-1:0]   M_BRESP;
  logic                S_AWVALID;
  logic [AW_W-1:0]     S_AWOUT;
  logic                S_AWREADY;
  logic                S_WVALID;
  logic [DATA_W-1:0]   S_WDATA;
  logic                S_WLAST;
  logic                S_WREADY;
  logic                S_BVALID;
  logic [RESP_W-1:0]   S_BRESP;
  logic                S_BREADY;
  logic [1:0]          GNT;
  logic                BUSY;

  int vec  = 0;
  int errs = 0;

  logic [11:0] aw_q[$];
  logic [8:0]  w_q[$];

  axi_wr_arbiter #(
    .AW_W(AW_W), .DATA_W(DATA_W),
    .RESP_W(RESP_W), .TIMEOUT_CYC(8)
  ) dut (
    .clk(clk), .rst(rst),
    .M_AWVALID(M_AWVALID), .M_AWOUT(M_AWOUT),
    .M_AWREADY(M_AWREADY),
    .M_WVALID(M_WVALID), .M_WDATA(M_WDATA),
    .M_WLAST(M_WLAST), .M_WREADY(M_WREADY),
    .M_BREADY(M_BREADY), .M_BVALID(M_BVALID),
    .M_BRESP(M_BRESP),
    .S_AWVALID(S_AWVALID), .S_AWOUT(S_AWOUT),
    .S_AWREADY(S_AWREADY),
    .S_WVALID(S_WVALID), .S_WDATA(S_WDATA),
    .S_WLAST(S_WLAST), .S_WREADY(S_WREADY),
    .S_BVALID(S_BVALID), .S_BRESP(S_BRESP),
    .S_BREADY(S_BREADY),
    .GNT(GNT), .BUSY(BUSY)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    vec++;
    assert (obs === exp) else begin
      errs++;
      $error("FAIL %s: got %0h, want %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  always @(negedge clk) begin : mon
    logic [31:0] e;
    if (S_AWVALID && S_AWREADY) begin
      e = 'x;
      if (aw_q.size() != 0) e = 32'(aw_q.pop_front());
      chk("s_aw", 32'(S_AWOUT), e);
    end
    if (S_WVALID && S_WREADY) begin
      e = 'x;
      if (w_q.size() != 0) e = 32'(w_q.pop_front());
      chk("s_w", 32'({S_WLAST, S_WDATA}), e);
    end
    chk("isolate", 32'((M_AWREADY | M_WREADY | M_BVALID) & ~GNT), 0);
  end

  task automatic do_reset();
    rst       = 1'b0;
    M_AWVALID = '0;
    M_AWOUT   = '0;
    M_WVALID  = '0;
    M_WDATA   = '0;
    M_WLAST   = '0;
    M_BREADY  = '0;
    S_AWREADY = 1'b0;
    S_WREADY  = 1'b0;
    S_BVALID  = 1'b0;
    S_BRESP   = '0;
    tick();
    tick();
    rst = 1'b1;
    #1;
    chk("rst_gnt", GNT, 0);
    chk("rst_busy", BUSY, 0);
    chk("rst_saw", S_AWVALID, 0);
    chk("rst_sw", S_WVALID, 0);
    chk("rst_mb", M_BVALID, 0);
    chk("rst_pri", dut.pri, 0);
    chk("rst_beats", dut.beats, 0);
  endtask

  // Runs AW and all W beats for master m; returns in RESP.
  task automatic aw_w(input int m, input logic [11:0] aw,
                      input int nb, input logic [7:0] base,
                      input logic [3:0] wpat, input bit keep);
    logic [1:0] oh;
    int n, b, k, pushed;
    oh = (m == 1) ? 2'b10 : 2'b01;
    M_AWVALID[m] = 1'b1;
    M_AWOUT[m*AW_W +: AW_W] = aw;
    aw_q.push_back(aw);
    #1;
    chk("req_quiet", S_AWVALID, 0);
    n = 0;
    do begin
      tick();
      n++;
    end while (GNT !== oh && n < 30);
    chk("grant", GNT, oh);
    chk("grant_lat", n, 1);
    S_AWREADY = 1'b1;
    #1;
    chk("s_awout", S_AWOUT, aw);
    chk("m_awready", M_AWREADY, oh);
    tick();
    if (!keep) M_AWVALID[m] = 1'b0;
    b = 0;
    k = 0;
    pushed = 0;
    while (b < nb && k < 40) begin
      M_WVALID[m] = 1'b1;
      M_WDATA[m*DATA_W +: DATA_W] = base + 8'h11 * 8'(b);
      M_WLAST[m] = (b == nb - 1);
      S_WREADY = (k < 4) ? wpat[k] : 1'b1;
      if (pushed == b) begin
        w_q.push_back({M_WLAST[m], M_WDATA[m*DATA_W +: DATA_W]});
        pushed++;
      end
      #1;
      if (S_WVALID && S_WREADY) b++;
      tick();
      k++;
    end
    chk("w_beats", b, nb);
    chk("beat_cnt", dut.beats, nb);
    M_WVALID[m] = 1'b0;
    M_WLAST[m]  = 1'b0;
    S_WREADY    = 1'b0;
  endtask

  task automatic b_ok(input int m, input logic [4:0] resp);
    logic [1:0] oh;
    oh = (m == 1) ? 2'b10 : 2'b01;
    M_BREADY[m] = 1'b1;
    S_BVALID    = 1'b1;
    S_BRESP     = resp;
    #1;
    chk("m_bvalid", M_BVALID, oh);
    chk("m_bresp", M_BRESP, resp);
    chk("s_bready", S_BREADY, 1);
    tick();
    S_BVALID = 1'b0;
    M_BREADY = '0;
    S_BRESP  = '0;
    #1;
    chk("done_gnt", GNT, 0);
    chk("done_busy", BUSY, 0);
    chk("done_pri", dut.pri, (m == 0) ? 1 : 0);
    chk("done_beats", dut.beats, 0);
  endtask

  initial begin
    do_reset();

    // single master 0, three beats
    aw_w(0, 12'hA53, 3, 8'h11, 4'hF, 1'b0);
    b_ok(0, 5'h00);

    // simultaneous requests after reset
    do_reset();
    M_AWVALID[1] = 1'b1;
    M_AWOUT[2*AW_W-1:AW_W] = 12'h6E7;
    aw_w(0, 12'h1C2, 2, 8'h40, 4'hF, 1'b0);
    b_ok(0, 5'h03);
    aw_w(1, 12'h6E7, 1, 8'h90, 4'hF, 1'b0);
    b_ok(1, 5'h04);

    // both masters keep requesting: grants alternate
    M_AWVALID[1] = 1'b1;
    aw_w(0, 12'h101, 1, 8'h01, 4'hF, 1'b1);
    b_ok(0, 5'h00);
    aw_w(1, 12'h202, 2, 8'h02, 4'hF, 1'b1);
    b_ok(1, 5'h01);
    aw_w(0, 12'h303, 1, 8'h03, 4'hF, 1'b1);
    b_ok(0, 5'h02);
    aw_w(1, 12'h404, 1, 8'h04, 4'hF, 1'b0);
    b_ok(1, 5'h05);
    M_AWVALID = '0;

    // W backpressure 1,0,0,1 across a two-beat burst
    aw_w(0, 12'h2D4, 2, 8'hA0, 4'b1001, 1'b0);
    b_ok(0, 5'h06);

    // reset in DATA after one beat
    M_AWVALID = 2'b01;
    M_AWOUT[AW_W-1:0] = 12'h5C1;
    aw_q.push_back(12'h5C1);
    S_AWREADY = 1'b1;
    tick();
    tick();
    M_AWVALID = '0;
    M_WVALID  = 2'b01;
    M_WDATA[DATA_W-1:0] = 8'h77;
    M_WLAST   = '0;
    S_WREADY  = 1'b1;
    w_q.push_back({1'b0, 8'h77});
    tick();
    chk("pre_rst_beats", dut.beats, 1);
    chk("pre_rst_pri", dut.pri, 1);
    M_WVALID = '0;
    S_WREADY = 1'b0;
    rst = 1'b0;
    tick();
    rst = 1'b1;
    chk("mid_rst_busy", BUSY, 0);
    chk("mid_rst_gnt", GNT, 0);
    chk("mid_rst_sw", S_WVALID, 0);
    chk("mid_rst_mw", M_WREADY, 0);
    chk("mid_rst_pri", dut.pri, 0);
    chk("mid_rst_beats", dut.beats, 0);
    aw_w(1, 12'h3B6, 1, 8'h44, 4'hF, 1'b0);
    b_ok(1, 5'h02);

    // withdrawn request in ADDR keeps PRI
    S_AWREADY = 1'b0;
    M_AWVALID = 2'b01;
    M_AWOUT[AW_W-1:0] = 12'hEEE;
    tick();
    chk("abort_gnt", GNT, 2'b01);
    chk("abort_saw", S_AWVALID, 1);
    M_AWVALID = '0;
    tick();
    chk("abort_idle", BUSY, 0);
    chk("abort_gnt0", GNT, 0);
    chk("abort_pri", dut.pri, 0);

`ifdef ARB_TIMEOUT_EN
    aw_w(0, 12'h0F0, 1, 8'h55, 4'hF, 1'b0);
    S_BVALID = 1'b0;
    M_BREADY = '0;
    for (int i = 0; i < 8; i++) begin
      chk("to_wait", M_BVALID, 0);
      tick();
    end
    chk("to_bvalid", M_BVALID, 2'b01);
    chk("to_bresp", M_BRESP, 5'h1F);
    M_BREADY = 2'b01;
    tick();
    M_BREADY = '0;
    chk("to_idle", BUSY, 0);
    chk("to_pri", dut.pri, 1);
`endif

    tick();
    chk("aw_q_drained", aw_q.size(), 0);
    chk("w_q_drained", w_q.size(), 0);
    $display("== %0d vectors applied, %0d miscompares ==", vec, errs);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
